// File: rtl/tag_array_nway.sv
// -----------------------------------------------------------------------------
// tag_array_nway
//
// N-way set-associative tag store with per-way valid bits and a one-cycle
// lookup pipeline. Provides hit detection, hit-way and victim-way selection,
// fill, invalidate-way and invalidate-all. Tag storage is a plain array with no
// reset; valid bits are cleared by a sweep that runs after reset and after every
// invalidate-all, one set per cycle.
//
// Optional feature macro: TAG_ARRAY_PLRU_EN
//   defined   : per-set tree pseudo-LRU (WAYS-1 bits per set, flop based)
//   undefined : single global round-robin pointer, advanced on every fill
//
// Ports
//   CK           clock, rising edge
//   RSTN         asynchronous active-low reset
//   req_valid    request strobe, taken when req_valid && req_ready
//   req_ready    high while the block accepts requests (not during a sweep)
//   req_op       00 lookup, 01 fill, 10 invalidate way, 11 invalidate all
//   req_index    set index
//   req_tag      tag to compare (lookup) or to write (fill)
//   req_way      target way for fill / invalidate way
//   resp_valid   one-cycle pulse, lookup result valid
//   resp_hit     lookup hit
//   resp_way     lowest matching way, 0 on miss
//   resp_victim  suggested fill way for the looked-up set
//   init_done    high once the valid sweep has completed
// -----------------------------------------------------------------------------
module tag_array_nway #(
    parameter int TAG_W = 22,
    parameter int IDX_W = 6,
    parameter int WAYS  = 2
) (
    input  logic                     CK,
    input  logic                     RSTN,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [IDX_W-1:0]         req_index,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic [$clog2(WAYS)-1:0]  req_way,
    output logic                     resp_valid,
    output logic                     resp_hit,
    output logic [$clog2(WAYS)-1:0]  resp_way,
    output logic [$clog2(WAYS)-1:0]  resp_victim,
    output logic                     init_done
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 1 << IDX_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_hit_q, resp_hit_d;
    logic [WAY_W-1:0] resp_way_q, resp_way_d;
    logic [WAY_W-1:0] resp_victim_q, resp_victim_d;

    logic             accept, do_lookup, do_fill, do_inv_way, do_inv_all, sweep_clr;
    logic [WAYS-1:0]  way_valid, way_match;
    logic             hit, any_invalid;
    logic [WAY_W-1:0] hit_way, first_invalid, policy_victim;

    assign req_ready  = (state_q == ST_RUN);
    assign init_done  = (state_q == ST_RUN);
    assign accept     = req_valid && req_ready;
    assign do_lookup  = accept && (req_op == 2'b00);
    assign do_fill    = accept && (req_op == 2'b01);
    assign do_inv_way = accept && (req_op == 2'b10);
    assign do_inv_all = accept && (req_op == 2'b11);
    assign sweep_clr  = (state_q == ST_INIT);

    // Per-way storage. Reads are combinational off req_index so a lookup the
    // cycle after a fill/invalidate to the same set sees the new contents.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [TAG_W-1:0] tag_mem [SETS];
        logic             valid_mem [SETS];
        logic             sel;

        assign sel = (req_way == WAY_W'(gi));

        always_ff @(posedge CK) begin
            if (do_fill && sel) begin
                tag_mem[req_index] <= req_tag;
            end
            if (sweep_clr) begin
                valid_mem[sweep_cnt_q] <= 1'b0;
            end else if ((do_fill || do_inv_way) && sel) begin
                valid_mem[req_index] <= do_fill;
            end
        end

        assign way_valid[gi] = valid_mem[req_index];
        assign way_match[gi] = way_valid[gi] && (tag_mem[req_index] == req_tag);
    end

    // Lowest matching way and lowest invalid way; scanning downwards lets the
    // lowest index win.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        any_invalid   = 1'b0;
        first_invalid = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_match[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_valid[w]) begin
                any_invalid   = 1'b1;
                first_invalid = WAY_W'(w);
            end
        end
    end

`ifdef TAG_ARRAY_PLRU_EN
    // Tree bits are kept in heap order: node n (1-based) is bit n-1, its
    // children are 2n and 2n+1, leaves WAYS..2*WAYS-1 map to ways 0..WAYS-1.
    // A bit value gives the direction the victim walk takes at that node.
    logic [WAYS-2:0]  plru_q [SETS];
    logic [WAYS-2:0]  plru_d [SETS];
    logic [WAYS-2:0]  plru_cur, plru_upd;
    logic [WAY_W-1:0] acc_way;
    logic             plru_we;

    assign plru_cur = plru_q[req_index];
    assign acc_way  = do_fill ? req_way : hit_way;
    assign plru_we  = do_fill || (do_lookup && hit);

    // The leading 1 of the heap index shifts out after WAY_W steps, leaving
    // exactly the leaf offset, i.e. the way number.
    always_comb begin : plru_walk
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] nidx;
        node = WAY_W'(1);
        nidx = '0;
        for (int l = 0; l < WAY_W; l++) begin
            nidx = node - 1'b1;
            node = (node << 1) | WAY_W'(plru_cur[nidx]);
        end
        policy_victim = node;
    end

    always_comb begin : plru_touch
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] nidx;
        logic             dir;
        plru_upd = plru_cur;
        node     = WAY_W'(1);
        nidx     = '0;
        dir      = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            dir            = acc_way[WAY_W-1-l];
            nidx           = node - 1'b1;
            plru_upd[nidx] = ~dir;
            node           = (node << 1) | WAY_W'(dir);
        end
    end

    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            plru_d[s] = plru_q[s];
        end
        if (do_inv_all) begin
            for (int s = 0; s < SETS; s++) begin
                plru_d[s] = '0;
            end
        end else if (plru_we) begin
            plru_d[req_index] = plru_upd;
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= plru_d[s];
            end
        end
    end
`else
    // WAYS is a power of two, so the natural wrap of the adder is the modulo.
    logic [WAY_W-1:0] rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (do_inv_all) begin
            rr_d = '0;
        end else if (do_fill) begin
            rr_d = rr_q + 1'b1;
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign policy_victim = rr_q;
`endif

    always_comb begin
        state_d       = state_q;
        sweep_cnt_d   = sweep_cnt_q;
        resp_valid_d  = do_lookup;
        resp_hit_d    = resp_hit_q;
        resp_way_d    = resp_way_q;
        resp_victim_d = resp_victim_q;

        if (state_q == ST_INIT) begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
            // all-ones means the last set is being cleared this cycle
            if (&sweep_cnt_q) begin
                state_d = ST_RUN;
            end
        end else if (do_inv_all) begin
            state_d     = ST_INIT;
            sweep_cnt_d = '0;
        end

        if (do_lookup) begin
            resp_hit_d    = hit;
            resp_way_d    = hit_way;
            resp_victim_d = any_invalid ? first_invalid : policy_victim;
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= ST_INIT;
            sweep_cnt_q   <= '0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_way_q    <= '0;
            resp_victim_q <= '0;
        end else begin
            state_q       <= state_d;
            sweep_cnt_q   <= sweep_cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_hit_q    <= resp_hit_d;
            resp_way_q    <= resp_way_d;
            resp_victim_q <= resp_victim_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_hit    = resp_hit_q;
    assign resp_way    = resp_way_q;
    assign resp_victim = resp_victim_q;

endmodule

// File: tb/tb_tag_array_nway.sv
// -----------------------------------------------------------------------------
// tb_tag_array_nway
//
// Directed bench for tag_array_nway (TAG_W=22, IDX_W=6, WAYS=2). A behavioural
// model of sets/ways/valid/replacement predicts every output; a negedge process
// compares the DUT to it each cycle. Hand-computed literal expectations pin the
// scenario results. Honours TAG_ARRAY_PLRU_EN for the replacement policy.
// -----------------------------------------------------------------------------
module tb_tag_array_nway;

    localparam int TAG_W = 22;
    localparam int IDX_W = 6;
    localparam int WAYS  = 2;
    localparam int SETS  = 64;
`ifdef TAG_ARRAY_PLRU_EN
    localparam int PLRU = 1;
`else
    localparam int PLRU = 0;
`endif

    logic             CK = 1'b0;
    logic             RSTN = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [IDX_W-1:0] req_index = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [0:0]       req_way = '0;
    logic             resp_valid;
    logic             resp_hit;
    logic [0:0]       resp_way;
    logic [0:0]       resp_victim;
    logic             init_done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int cyc;

    tag_array_nway #(.TAG_W(TAG_W), .IDX_W(IDX_W), .WAYS(WAYS)) dut (
        .CK(CK), .RSTN(RSTN),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_index(req_index), .req_tag(req_tag), .req_way(req_way),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_victim(resp_victim), .init_done(init_done)
    );

    always #5 CK = ~CK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [TAG_W-1:0] m_tag [SETS][WAYS];
    bit               m_val [SETS][WAYS];
    bit               m_ready = 1'b0;
    int               m_cnt = 0;
    bit               e_rv = 1'b0, e_hit = 1'b0;
    int               e_way = 0, e_vic = 0;
`ifdef TAG_ARRAY_PLRU_EN
    int               m_evict [SETS];   // per-set way to evict (the non-MRU way)
`else
    int               m_rr = 0;
`endif

    always @(posedge CK or negedge RSTN) begin : model
        int hw, iw, pol;
        if (!RSTN) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            e_rv    = 1'b0;
            e_hit   = 1'b0;
            e_way   = 0;
            e_vic   = 0;
`ifdef TAG_ARRAY_PLRU_EN
            for (int s = 0; s < SETS; s++) m_evict[s] = 0;
`else
            m_rr = 0;
`endif
        end else begin
            e_rv = 1'b0;
            if (!m_ready) begin
                for (int w = 0; w < WAYS; w++) m_val[m_cnt][w] = 1'b0;
                m_cnt++;
                if (m_cnt == SETS) m_ready = 1'b1;
            end else if (req_valid) begin
                case (req_op)
                    2'b00: begin
                        hw = -1;
                        iw = -1;
                        for (int w = 0; w < WAYS; w++) begin
                            if (hw < 0 && m_val[req_index][w] && m_tag[req_index][w] == req_tag) hw = w;
                            if (iw < 0 && !m_val[req_index][w]) iw = w;
                        end
`ifdef TAG_ARRAY_PLRU_EN
                        pol = m_evict[req_index];
                        if (hw >= 0) m_evict[req_index] = 1 - hw;
`else
                        pol = m_rr;
`endif
                        e_rv  = 1'b1;
                        e_hit = (hw >= 0);
                        e_way = (hw >= 0) ? hw : 0;
                        e_vic = (iw >= 0) ? iw : pol;
                    end
                    2'b01: begin
                        m_tag[req_index][req_way] = req_tag;
                        m_val[req_index][req_way] = 1'b1;
`ifdef TAG_ARRAY_PLRU_EN
                        m_evict[req_index] = 1 - int'(req_way);
`else
                        m_rr = (m_rr + 1) % WAYS;
`endif
                    end
                    2'b10: m_val[req_index][req_way] = 1'b0;
                    default: begin
                        m_ready = 1'b0;
                        m_cnt   = 0;
`ifdef TAG_ARRAY_PLRU_EN
                        for (int s = 0; s < SETS; s++) m_evict[s] = 0;
`else
                        m_rr = 0;
`endif
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CK) begin
        if (chk_en) begin
            check("cyc.req_ready", req_ready, m_ready);
            check("cyc.init_done", init_done, m_ready);
            check("cyc.resp_valid", resp_valid, e_rv);
            check("cyc.resp_hit", resp_hit, e_hit);
            check("cyc.resp_way", resp_way, e_way);
            check("cyc.resp_victim", resp_victim, e_vic);
        end
    end

    // Called at a negedge; presents one request for one cycle, returns at the
    // next negedge (where a lookup's response is visible).
    task automatic drive(input logic [1:0] op, input int idx, input logic [TAG_W-1:0] tag, input int way);
        req_op    = op;
        req_index = IDX_W'(idx);
        req_tag   = tag;
        req_way   = 1'(way);
        req_valid = 1'b1;
        $display("txn op=%0d idx=%0d tag=0x%0h way=%0d", op, idx, tag, way);
        @(negedge CK);
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string name, input int hit, input int way, input int vic);
        check({name, ".valid"}, resp_valid, 1);
        check({name, ".hit"}, resp_hit, hit);
        check({name, ".way"}, resp_way, way);
        check({name, ".victim"}, resp_victim, vic);
    endtask

    // Release reset mid-low-phase and count cycles until init_done rises.
    task automatic release_and_count(input string name);
        @(negedge CK);
        #2 RSTN = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge CK);
            if (k < SETS) begin
                check({name, ".busy"}, {31'd0, req_ready | init_done}, 0);
            end
            if (init_done) begin
                cyc = k;
                break;
            end
        end
        check({name, ".sweep_len"}, cyc, SETS);
        check({name, ".ready"}, req_ready, 1);
    endtask

    initial begin
        #1 RSTN = 1'b0;
        #1 chk_en = 1'b1;
        check("rst.req_ready", req_ready, 0);
        check("rst.init_done", init_done, 0);
        check("rst.resp_valid", resp_valid, 0);
        check("rst.resp_victim", resp_victim, 0);
        repeat (2) @(negedge CK);

        // Release; a fill presented during the sweep must be ignored.
        @(negedge CK);
        #2 RSTN = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge CK);
            if (k == 10) begin
                req_op = 2'b01; req_index = 6'd9; req_tag = 22'h3FFFFF; req_way = 1'b0;
                req_valid = 1'b1;
            end
            if (k == 12) req_valid = 1'b0;
            if (k < SETS) check("init.busy", {31'd0, req_ready | init_done}, 0);
            if (init_done) begin
                cyc = k;
                break;
            end
        end
        check("init.sweep_len", cyc, SETS);

        drive(2'b00, 9, 22'h3FFFFF, 0);   expect_resp("ignored_fill", 0, 0, 0);

        drive(2'b01, 9, 22'h11, 0);
        drive(2'b01, 9, 22'h22, 1);
        drive(2'b00, 9, 22'h33, 0);       expect_resp("set9_miss", 0, 0, 0);
        drive(2'b00, 9, 22'h11, 0);       expect_resp("set9_hit0", 1, 0, 0);
        drive(2'b00, 9, 22'h33, 0);       expect_resp("set9_miss2", 0, 0, PLRU ? 1 : 0);

        drive(2'b01, 5, 22'h2ABCDE, 1);
        drive(2'b00, 5, 22'h2ABCDE, 0);   expect_resp("set5_hit1", 1, 1, 0);

        drive(2'b00, 9, 22'h33, 0);       expect_resp("set9_miss3", 0, 0, 1);
        drive(2'b00, 9, 22'h22, 0);       expect_resp("set9_hit1", 1, 1, 1);
        @(negedge CK);
        check("hold.valid", resp_valid, 0);
        check("hold.hit", resp_hit, 1);
        check("hold.way", resp_way, 1);
        drive(2'b00, 9, 22'h33, 0);       expect_resp("set9_miss4", 0, 0, PLRU ? 0 : 1);

        drive(2'b10, 5, 22'h0, 1);
        drive(2'b00, 5, 22'h2ABCDE, 0);   expect_resp("set5_inv", 0, 0, 0);

        // Invalidate-all: ready drops next cycle, full sweep follows.
        drive(2'b11, 0, 22'h0, 0);
        check("invall.ready_drop", req_ready, 0);
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge CK);
            if (req_ready) begin
                cyc = k;
                break;
            end
        end
        check("invall.sweep_len", cyc, SETS);
        drive(2'b00, 9, 22'h11, 0);       expect_resp("invall_miss", 0, 0, 0);

        // Reset 20 cycles into an invalidate-all sweep.
        drive(2'b01, 9, 22'h11, 0);
        drive(2'b01, 9, 22'h22, 1);
        drive(2'b11, 0, 22'h0, 0);
        repeat (19) @(negedge CK);
        #2 RSTN = 1'b0;
        #1 check("midrst.ready", req_ready, 0);
        check("midrst.resp_valid", resp_valid, 0);
        @(negedge CK);
        release_and_count("midrst");
        drive(2'b00, 9, 22'h11, 0);       expect_resp("post_rst_a", 0, 0, 0);
        drive(2'b00, 9, 22'h22, 0);       expect_resp("post_rst_b", 0, 0, 0);
        drive(2'b00, 5, 22'h2ABCDE, 0);   expect_resp("post_rst_c", 0, 0, 0);
        @(negedge CK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tag_array_nway.md
Name: tag_array_nway

Overview:
- Parametrised N-way set-associative tag store with per-way valid bits and a 1-cycle lookup pipeline.
- Provides hit detection, hit-way and victim-way selection, fill, and invalidate operations.
- Sits between the L1 cache controller and the data array. Supersedes direct use of single-way tag macros.
- Storage is a behavioural array with no reset. Valid bits are cleared by a hardware init sweep.

Parameters:
TAG_W, 22, tag width in bits
IDX_W, 6, set index width; SETS = 2**IDX_W
WAYS, 2, associativity; power of 2, >= 2; WAY_W = clog2(WAYS) is derived as a localparam

Ports:
CK  in  1  clock, rising edge
RSTN  in  1  reset, asynchronous, active-low
req_valid  in  1  request strobe; accepted when req_valid && req_ready
req_ready  out  1  block can accept a request
req_op  in  2  00 lookup, 01 fill, 10 invalidate way, 11 invalidate all
req_index  in  IDX_W  set index
req_tag  in  TAG_W  tag to compare (lookup) or write (fill)
req_way  in  WAY_W  target way for fill / invalidate way
resp_valid  out  1  lookup result valid; one-cycle pulse
resp_hit  out  1  lookup hit
resp_way  out  WAY_W  hit way; 0 on miss
resp_victim  out  WAY_W  suggested fill way for the looked-up set
init_done  out  1  high once the valid sweep has completed

Behaviour:
- Reset is asynchronous and active-low (RSTN), single clock CK.
- Reset values: req_ready=0, resp_valid=0, resp_hit=0, resp_way=0, resp_victim=0, init_done=0. FSM enters INIT with sweep counter=0. Replacement state is cleared to 0.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle, clear the valid bit of all ways in set[counter], then increment the counter.
  - After set SETS-1 is cleared, go to RUN and set init_done=1.
  - Sweep takes exactly SETS cycles. req_ready=0 throughout.
- RUN:
  - req_ready=1 every cycle. No back-pressure; at most one request per cycle.
- Lookup (op 00):
  - Registered response: resp_valid=1 on the cycle after acceptance.
  - resp_hit=1 if any way in the set has valid && tag==req_tag.
  - resp_way = lowest matching way.
  - resp_victim = lowest invalid way if any way is invalid, else the replacement-policy way.
  - resp_* hold their values when resp_valid=0.
- Fill (op 01): write tag and valid=1 into (req_index, req_way) at the accepting edge. No response.
- Invalidate way (op 10): clear valid of (req_index, req_way). No response.
- Invalidate all (op 11):
  - At the accepting edge: init_done=0, counter=0, FSM to INIT. req_ready drops the next cycle.
  - Sweep repeats in full (SETS cycles).
  - Replacement state is cleared to 0 at the same edge.
- Write-then-read: a lookup accepted the cycle after a fill or invalidate to the same set sees the updated entry.
- Replacement update:
  - A lookup hit marks the hit way MRU.
  - A fill marks req_way MRU.
  - Misses and invalidates leave replacement state unchanged.
- RSTN asserted mid-sweep or mid-lookup: immediately return to reset values. Any pending response is dropped and the sweep restarts from set 0.
- Requests with req_valid=1 while req_ready=0 are ignored, not queued.

Optional Feature:
Macro: TAG_ARRAY_PLRU_EN
- Defined:
  - Tree pseudo-LRU per set, WAYS-1 bits per set, flop-based and cleared by reset and by invalidate-all.
  - Victim = the way reached by following the tree bits away from the most recently used way.
  - Update on hit/fill flips the tree bits on the path to point away from the accessed way.
- Not defined:
  - A single global round-robin pointer of WAY_W bits, reset to 0.
  - Victim = pointer value. Pointer increments (wrapping WAYS-1 -> 0) on every accepted fill. Hits do not change it.

Test Plan:
- RSTN low 3 cycles, then high (IDX_W=6): req_ready=0 and init_done=0 for exactly 64 cycles; init_done=1 and req_ready=1 on cycle 64.
- Fill idx 5, way 1, tag 0x2ABCDE; next cycle lookup idx 5, tag 0x2ABCDE: resp_valid=1, resp_hit=1, resp_way=1, resp_victim=0 (way 0 invalid).
- Fill idx 9 ways 0 and 1 with tags 0x11 and 0x22; lookup idx 9 tag 0x33: resp_hit=0, resp_way=0. resp_victim=0 with PLRU (way 1 is MRU); with round-robin the pointer is 0 after 2 fills, so resp_victim=0.
- After the above, lookup idx 9 tag 0x11 (hit way 0), then lookup tag 0x33: PLRU resp_victim=1; round-robin resp_victim=0.
- Invalidate way 1 at idx 5, then lookup idx 5 tag 0x2ABCDE: resp_hit=0, resp_victim=0.
- Issue invalidate-all, then pulse RSTN low at sweep cycle 20: sweep restarts, init_done rises 64 cycles after RSTN release, and every prior tag misses.
